// File: rtl/font_rom_arbiter_if.sv
// Secondary-client port of the font ROM arbiter: valid/ready request
// channel plus a pulsed read-data return.
interface font_rom_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int FONT_W = 8
);
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic              b_ready;
  logic              b_rvalid;
  logic [FONT_W-1:0] b_rdata;

  // Client side: issues requests, consumes returned glyph rows.
  modport master (
    output b_valid,
    output b_addr,
    input  b_ready,
    input  b_rvalid,
    input  b_rdata
  );

  // Arbiter side.
  modport slave (
    input  b_valid,
    input  b_addr,
    output b_ready,
    output b_rvalid,
    output b_rdata
  );
endinterface

// File: rtl/font_rom_arbiter.sv
// Shares one synchronous font ROM between the video fetch stage (absolute
// priority, fixed latency) and a secondary text client with a one-entry holding register.
module font_rom_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int FONT_W  = 8,
  parameter int ROM_LAT = 1,
  parameter int WAIT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vid_en,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [FONT_W-1:0] vid_q,
  font_rom_arbiter_if.slave b_bus,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [FONT_W-1:0] rom_q,
  output logic [WAIT_W-1:0] b_wait_max
);

  logic              pend_v_reg;
  logic              pend_v_next;
  logic [ADDR_W-1:0] pend_addr_reg;
  logic [ADDR_W-1:0] pend_addr_next;
  logic              accept;
  logic              issue;

  logic [ROM_LAT-1:0] tag_reg;
  logic [ROM_LAT-1:0] tag_next;
  logic               capture;

  logic              b_rvalid_reg;
  logic [FONT_W-1:0] b_rdata_reg;
  logic [FONT_W-1:0] b_rdata_next;

  logic [WAIT_W-1:0] cur_wait_reg;
  logic [WAIT_W-1:0] cur_wait_next;
  logic [WAIT_W-1:0] wait_max_reg;
  logic [WAIT_W-1:0] wait_max_next;

  // Video owns the ROM whenever vid_en is high; the pending request only
  // slips into cycles where the renderer is not fetching.
  always_comb begin
    accept   = b_bus.b_valid & ~pend_v_reg;
    issue    = pend_v_reg & ~vid_en;
    rom_addr = issue ? pend_addr_reg : vid_addr;
  end

  assign vid_q          = rom_q;
  assign b_bus.b_ready  = ~pend_v_reg;
  assign b_bus.b_rvalid = b_rvalid_reg;
  assign b_bus.b_rdata  = b_rdata_reg;
  assign b_wait_max     = wait_max_reg;

  // Accept and issue are mutually exclusive: accept needs an empty slot,
  // issue needs a full one.
  always_comb begin
    pend_v_next    = pend_v_reg;
    pend_addr_next = pend_addr_reg;
    if (accept) begin
      pend_v_next    = 1'b1;
      pend_addr_next = b_bus.b_addr;
    end else if (issue) begin
      pend_v_next    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v_reg    <= 1'b0;
      pend_addr_reg <= '0;
    end else begin
      pend_v_reg    <= pend_v_next;
      pend_addr_reg <= pend_addr_next;
    end
  end

  // Tag shift register mirrors the ROM pipeline so the capture lines up
  // with rom_q for the issued address.
  generate
    for (genvar gi = 0; gi < ROM_LAT; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign tag_next[gi] = issue;
      end else begin : g_body
        assign tag_next[gi] = tag_reg[gi-1];
      end
    end
  endgenerate

  assign capture = tag_reg[ROM_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_reg <= '0;
    end else begin
      tag_reg <= tag_next;
    end
  end

  always_comb begin
    b_rdata_next = b_rdata_reg;
    if (capture) begin
      b_rdata_next = rom_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_rvalid_reg <= 1'b0;
      b_rdata_reg  <= '0;
    end else begin
      b_rvalid_reg <= capture;
      b_rdata_reg  <= b_rdata_next;
    end
  end

  // Stall counter saturates so a very long blanking-free stretch still
  // reports all-ones instead of wrapping to a small number.
  always_comb begin
    cur_wait_next = cur_wait_reg;
    wait_max_next = wait_max_reg;
    if (issue) begin
      cur_wait_next = '0;
      if (cur_wait_reg > wait_max_reg) begin
        wait_max_next = cur_wait_reg;
      end
    end else if (pend_v_reg && vid_en && !(&cur_wait_reg)) begin
      cur_wait_next = cur_wait_reg + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_wait_reg <= '0;
      wait_max_reg <= '0;
    end else begin
      cur_wait_reg <= cur_wait_next;
      wait_max_reg <= wait_max_next;
    end
  end

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Drives two arbiters (ROM_LAT=1/WAIT_W=16 and ROM_LAT=3/WAIT_W=4) with the
// same stimulus and compares both against an event-level reference model.
module tb_font_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vid_en;
  logic [11:0] vid_addr;
  logic        b_valid;
  logic [11:0] b_addr;

  logic [11:0] rom_addr0, rom_addr1;
  logic [7:0]  rom_q0, rom_q1, vid_q0, vid_q1;
  logic [15:0] wmax0;
  logic [3:0]  wmax1;

  always #5 clk = ~clk;

  font_rom_arbiter_if #(.ADDR_W(12), .FONT_W(8)) bif0 ();
  font_rom_arbiter_if #(.ADDR_W(12), .FONT_W(8)) bif1 ();

  assign bif0.b_valid = b_valid;
  assign bif0.b_addr  = b_addr;
  assign bif1.b_valid = b_valid;
  assign bif1.b_addr  = b_addr;

  font_rom_arbiter #(.ADDR_W(12), .FONT_W(8), .ROM_LAT(1), .WAIT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .vid_en(vid_en), .vid_addr(vid_addr), .vid_q(vid_q0),
    .b_bus(bif0.slave), .rom_addr(rom_addr0), .rom_q(rom_q0), .b_wait_max(wmax0)
  );

  font_rom_arbiter #(.ADDR_W(12), .FONT_W(8), .ROM_LAT(3), .WAIT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .vid_en(vid_en), .vid_addr(vid_addr), .vid_q(vid_q1),
    .b_bus(bif1.slave), .rom_addr(rom_addr1), .rom_q(rom_q1), .b_wait_max(wmax1)
  );

  function automatic logic [7:0] rom_fn(logic [11:0] a);
    logic [11:0] t;
    t = a * 12'd173 + 12'd91;
    return t[7:0] ^ {t[11:8], t[11:8]};
  endfunction

  // Synchronous ROMs with 1 and 3 cycles of latency.
  logic [11:0] rp0;
  logic [11:0] rp1 [3];
  always @(posedge clk) begin
    rp0    <= rom_addr0;
    rp1[0] <= rom_addr1;
    rp1[1] <= rp1[0];
    rp1[2] <= rp1[1];
  end
  assign rom_q0 = rom_fn(rp0);
  assign rom_q1 = rom_fn(rp1[2]);

  // Reference model state
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          m_pend;
  logic [11:0] m_paddr;
  int          m_stall;
  int          m_wmax [2];
  bit          m_rvalid [2];
  logic [7:0]  m_rdata [2];
  bit          m_acc;
  bit          issued_at [8192];
  logic [7:0]  data_at [8192];
  logic [11:0] addr_hist [8192];
  int          lat [2] = '{1, 3};
  int          lim [2] = '{65535, 15};
  int          pulse0, pulse1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic do_checks();
    bit          iss;
    logic [11:0] ea;
    iss = m_pend && !vid_en;
    ea  = iss ? m_paddr : vid_addr;
    chk("u0.rom_addr", {20'd0, rom_addr0}, {20'd0, ea});
    chk("u1.rom_addr", {20'd0, rom_addr1}, {20'd0, ea});
    if (cyc >= 4) begin
      chk("u0.vid_q", {24'd0, vid_q0}, {24'd0, rom_fn(addr_hist[cyc-1])});
      chk("u1.vid_q", {24'd0, vid_q1}, {24'd0, rom_fn(addr_hist[cyc-3])});
    end
    chk("u0.b_ready", {31'd0, bif0.b_ready}, {31'd0, !m_pend});
    chk("u1.b_ready", {31'd0, bif1.b_ready}, {31'd0, !m_pend});
    chk("u0.b_rvalid", {31'd0, bif0.b_rvalid}, {31'd0, m_rvalid[0]});
    chk("u1.b_rvalid", {31'd0, bif1.b_rvalid}, {31'd0, m_rvalid[1]});
    chk("u0.b_rdata", {24'd0, bif0.b_rdata}, {24'd0, m_rdata[0]});
    chk("u1.b_rdata", {24'd0, bif1.b_rdata}, {24'd0, m_rdata[1]});
    chk("u0.b_wait_max", {16'd0, wmax0}, 32'(m_wmax[0]));
    chk("u1.b_wait_max", {28'd0, wmax1}, 32'(m_wmax[1]));
    if (bif0.b_rvalid === 1'b1) pulse0++;
    if (bif1.b_rvalid === 1'b1) pulse1++;
  endtask

  // Clock-edge view: a read issued in cycle t returns data from cycle
  // t+lat+1; the stall statistic is the saturated length of each stall.
  task automatic model_update();
    bit          iss;
    bit          pend_old;
    logic [11:0] ea;
    int          idx;
    iss = m_pend && !vid_en;
    ea  = iss ? m_paddr : vid_addr;
    addr_hist[cyc] = ea;
    m_acc = 0;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        idx = cyc - lat[i];
        if (idx >= 0 && issued_at[idx]) begin
          m_rvalid[i] = 1;
          m_rdata[i]  = data_at[idx];
        end else begin
          m_rvalid[i] = 0;
        end
      end
      pend_old = m_pend;
      if (iss) begin
        issued_at[cyc] = 1;
        data_at[cyc]   = rom_fn(m_paddr);
        for (int i = 0; i < 2; i++) begin
          if ((m_stall < lim[i] ? m_stall : lim[i]) > m_wmax[i])
            m_wmax[i] = (m_stall < lim[i]) ? m_stall : lim[i];
        end
        m_stall = 0;
        m_pend  = 0;
      end else if (m_pend && vid_en) begin
        m_stall++;
      end
      if (!pend_old && b_valid) begin
        m_pend  = 1;
        m_paddr = b_addr;
        m_acc   = 1;
      end
    end
    cyc++;
  endtask

  task automatic model_reset();
    for (int k = (cyc > 4 ? cyc - 4 : 0); k <= cyc; k++) issued_at[k] = 0;
    m_pend  = 0;
    m_paddr = '0;
    m_stall = 0;
    for (int i = 0; i < 2; i++) begin
      m_wmax[i]   = 0;
      m_rvalid[i] = 0;
      m_rdata[i]  = '0;
    end
  endtask

  task automatic step();
    vid_addr = 12'($urandom);
    @(negedge clk);
    do_checks();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    int guard;
    vid_en  = 1'b0;
    vid_addr = '0;
    b_valid = 1'b0;
    b_addr  = '0;
    do_reset(4);

    // Idle secondary read of 0x123
    b_valid = 1'b1;
    b_addr  = 12'h123;
    step();
    b_valid = 1'b0;
    repeat (6) step();
    chk("idle_rdata_u0", {24'd0, bif0.b_rdata}, {24'd0, rom_fn(12'h123)});
    chk("idle_rdata_u1", {24'd0, bif1.b_rdata}, {24'd0, rom_fn(12'h123)});

    // Video priority: pending 0x040 while vid_en is high for 37 cycles,
    // vid_en rising in the very cycle the request becomes pending.
    b_valid = 1'b1;
    b_addr  = 12'h040;
    step();
    b_valid = 1'b0;
    vid_en  = 1'b1;
    repeat (37) step();
    vid_en  = 1'b0;
    repeat (7) step();
    chk("prio_wait37", {16'd0, wmax0}, 32'd37);
    chk("prio_wait_sat", {28'd0, wmax1}, 32'd15);
    chk("prio_rdata", {24'd0, bif0.b_rdata}, {24'd0, rom_fn(12'h040)});

    // Throughput: b_valid held, three addresses
    pulse0 = 0;
    pulse1 = 0;
    k = 0;
    guard = 0;
    b_valid = 1'b1;
    while (k < 3 && guard < 20) begin
      b_addr = 12'h010 + 12'(k);
      step();
      if (m_acc) k++;
      guard++;
    end
    b_valid = 1'b0;
    repeat (6) step();
    chk("thru_pulses_u0", 32'(pulse0), 32'd3);
    chk("thru_pulses_u1", 32'(pulse1), 32'd3);

    // Reset with one read in flight and one pending
    b_valid = 1'b1;
    b_addr  = 12'h2AA;
    step();
    b_valid = 1'b0;
    step();
    b_valid = 1'b1;
    b_addr  = 12'h355;
    vid_en  = 1'b1;
    step();
    b_valid = 1'b0;
    pulse0 = 0;
    pulse1 = 0;
    do_reset(2);
    vid_en = 1'b0;
    repeat (6) step();
    chk("rst_pulses_u0", 32'(pulse0), 32'd0);
    chk("rst_pulses_u1", 32'(pulse1), 32'd0);
    chk("rst_wait_max", {16'd0, wmax0}, 32'd0);

    // Saturation: 20-cycle stall
    b_valid = 1'b1;
    b_addr  = 12'h7F0;
    step();
    b_valid = 1'b0;
    vid_en  = 1'b1;
    repeat (20) step();
    vid_en  = 1'b0;
    repeat (6) step();
    chk("sat_wait_u0", {16'd0, wmax0}, 32'd20);
    chk("sat_wait_u1", {28'd0, wmax1}, 32'd15);

    // Random traffic with bursty video and occasional resets
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(7) == 0) vid_en = ~vid_en;
      b_valid = 1'($urandom_range(1));
      b_addr  = 12'($urandom);
      if ($urandom_range(499) == 0) do_reset(1);
      else step();
    end
    vid_en  = 1'b0;
    b_valid = 1'b0;
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
